// File: rtl/ddr3_loopback_traffic_checker.sv
// Loopback traffic source/checker for ddr3_memory_controller: writes an incrementing
// pattern, reads it back, and reports pass/fail, error count and first failing address.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start after reset
// WRITE   | issuing writes of the pattern to addresses 0..N-1
// READ    | issuing reads and checking returned data
// DONE    | run complete, pass/error_count valid until next start
// TIMEOUT | watchdog expired with no handshake progress
module ddr3_loopback_traffic_checker #(
   parameter int ADDRESS_BITWIDTH      = 15,
   parameter int BANK_ADDRESS_BITWIDTH = 3,
   parameter int DQ_BITWIDTH           = 8,
   parameter int NUM_OF_TEST_DATA      = 4,
   parameter int DATA_SEED             = 0,
   parameter int TIMEOUT_CYCLES        = 65535
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic                                             start,
   output logic                                             write_enable,
   output logic                                             read_enable,
   output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
   output logic [DQ_BITWIDTH-1:0]                           data_to_ram,
   input  logic                                             wr_accept,
   input  logic                                             rd_accept,
   input  logic                                             rd_data_valid,
   input  logic [DQ_BITWIDTH-1:0]                           data_from_ram,
   output logic                                             busy,
   output logic                                             done,
   output logic                                             pass,
   output logic                                             timeout,
   output logic [7:0]                                       error_count,
   output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address,
   output logic [2:0]                                       state
);

   localparam int ADDR_W = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
   localparam int IDX_W  = $clog2(NUM_OF_TEST_DATA + 1);
   localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_TEST_DATA - 1);
   localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_OF_TEST_DATA);
   localparam logic [WD_W-1:0]  WD_INIT  = WD_W'(TIMEOUT_CYCLES);
   localparam logic [DQ_BITWIDTH-1:0] SEED = DQ_BITWIDTH'(DATA_SEED);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_READ    = 3'd2,
      ST_DONE    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [IDX_W-1:0]       wr_idx;
   logic [IDX_W-1:0]       rd_issue_idx;
   logic [IDX_W-1:0]       rd_chk_idx;
   logic [WD_W-1:0]        wd_q;
   logic                   start_go;
   logic                   wr_hs;
   logic                   rd_hs;
   logic                   chk_hs;
   logic                   mismatch;
   logic                   progress;
   logic                   wd_expired;
   logic [DQ_BITWIDTH-1:0] expected_data;
   logic [IDX_W-1:0]       wr_idx_inc;
   logic [IDX_W-1:0]       rd_issue_inc;
   logic [IDX_W-1:0]       rd_chk_inc;

   assign state = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      start_go      = 1'b0;
      wr_hs         = 1'b0;
      rd_hs         = 1'b0;
      chk_hs        = 1'b0;
      mismatch      = 1'b0;
      progress      = 1'b0;
      wd_expired    = (wd_q == '0);
      expected_data = SEED + DQ_BITWIDTH'(rd_chk_idx);
      wr_idx_inc    = wr_idx + 1'b1;
      rd_issue_inc  = rd_issue_idx + 1'b1;
      rd_chk_inc    = rd_chk_idx + 1'b1;
      case (state_q)
         ST_IDLE, ST_DONE, ST_TIMEOUT: begin
            if (start) begin
               start_go = 1'b1;
               state_d  = ST_WRITE;
            end
         end
         ST_WRITE: begin
            wr_hs    = wr_accept;
            progress = wr_accept;
            if (wr_hs && (wr_idx == LAST_IDX)) begin
               state_d = ST_READ;
            end else if (!progress && wd_expired) begin
               state_d = ST_TIMEOUT;
            end
         end
         ST_READ: begin
            rd_hs    = rd_accept && (rd_issue_idx < NUM_IDX);
            chk_hs   = rd_data_valid;
            progress = rd_accept || rd_data_valid;
            mismatch = chk_hs && (data_from_ram != expected_data);
            if (chk_hs && (rd_chk_idx == LAST_IDX)) begin
               state_d = ST_DONE;
            end else if (!progress && wd_expired) begin
               state_d = ST_TIMEOUT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_idx              <= '0;
         rd_issue_idx        <= '0;
         rd_chk_idx          <= '0;
         wd_q                <= '0;
         write_enable        <= 1'b0;
         read_enable         <= 1'b0;
         i_user_data_address <= '0;
         data_to_ram         <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
         pass                <= 1'b0;
         timeout             <= 1'b0;
         error_count         <= '0;
         first_error_address <= '0;
      end else if (start_go) begin
         wr_idx              <= '0;
         rd_issue_idx        <= '0;
         rd_chk_idx          <= '0;
         wd_q                <= WD_INIT;
         write_enable        <= 1'b1;
         read_enable         <= 1'b0;
         i_user_data_address <= '0;
         data_to_ram         <= SEED;
         busy                <= 1'b1;
         done                <= 1'b0;
         pass                <= 1'b0;
         timeout             <= 1'b0;
         error_count         <= '0;
         first_error_address <= '0;
      end else begin
         // Watchdog is a down-counter reloaded on any handshake activity.
         if (busy) begin
            if (progress) begin
               wd_q <= WD_INIT;
            end else if (!wd_expired) begin
               wd_q <= wd_q - 1'b1;
            end
         end
         if (wr_hs) begin
            wr_idx <= wr_idx_inc;
            if (wr_idx == LAST_IDX) begin
               write_enable        <= 1'b0;
               read_enable         <= 1'b1;
               i_user_data_address <= '0;
            end else begin
               i_user_data_address <= ADDR_W'(wr_idx_inc);
               data_to_ram         <= SEED + DQ_BITWIDTH'(wr_idx_inc);
            end
         end
         if (rd_hs) begin
            rd_issue_idx        <= rd_issue_inc;
            i_user_data_address <= ADDR_W'(rd_issue_inc);
            if (rd_issue_idx == LAST_IDX) begin
               read_enable <= 1'b0;
            end
         end
         if (chk_hs) begin
            rd_chk_idx <= rd_chk_inc;
            if (mismatch) begin
               if (error_count != 8'hff) begin
                  error_count <= error_count + 8'd1;
               end
               if (error_count == 8'd0) begin
                  first_error_address <= ADDR_W'(rd_chk_idx);
               end
            end
            if (rd_chk_idx == LAST_IDX) begin
               done <= 1'b1;
               pass <= (error_count == 8'd0) && !mismatch;
               busy <= 1'b0;
            end
         end
         if (state_d == ST_TIMEOUT && state_q != ST_TIMEOUT) begin
            timeout      <= 1'b1;
            done         <= 1'b1;
            pass         <= 1'b0;
            busy         <= 1'b0;
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ddr3_loopback_traffic_checker.sv
// Bench for ddr3_loopback_traffic_checker: a behavioural controller/memory model drives two
// instances (4-word run and 300-word wrapping run); a scoreboard checks every request.
module tb_ddr3_loopback_traffic_checker;

   logic clk;
   logic [1:0] rst;
   logic [1:0] start;
   logic [1:0] wr_acc;
   logic [1:0] rd_acc;
   logic [1:0] rd_vld;
   logic [1:0][7:0] dfr;

   wire [1:0]       we;
   wire [1:0]       re;
   wire [1:0][17:0] addr;
   wire [1:0][7:0]  dtr;
   wire [1:0]       busy;
   wire [1:0]       done;
   wire [1:0]       pass;
   wire [1:0]       tmo;
   wire [1:0][7:0]  ec;
   wire [1:0][17:0] fea;
   wire [1:0][2:0]  st;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int wr_gap [2];
   int rd_gap [2];
   int rd_lat [2];
   int corrupt [2];
   logic [1:0] no_wr;
   logic [1:0] spur;
   int wr_cnt [2];
   int rd_cnt [2];
   int rd_total [2];
   int coinc [2];

   int         exp_wa [2][$];
   int         exp_wd [2][$];
   int         exp_ra [2][$];
   int         ret_due [2][$];
   logic [7:0] ret_dat [2][$];
   logic [7:0] mem [2][512];

   ddr3_loopback_traffic_checker #(
      .NUM_OF_TEST_DATA(4), .DATA_SEED(0), .TIMEOUT_CYCLES(100)
   ) dut_a (
      .clk(clk), .reset(rst[0]), .start(start[0]),
      .write_enable(we[0]), .read_enable(re[0]), .i_user_data_address(addr[0]),
      .data_to_ram(dtr[0]), .wr_accept(wr_acc[0]), .rd_accept(rd_acc[0]),
      .rd_data_valid(rd_vld[0]), .data_from_ram(dfr[0]), .busy(busy[0]),
      .done(done[0]), .pass(pass[0]), .timeout(tmo[0]), .error_count(ec[0]),
      .first_error_address(fea[0]), .state(st[0])
   );

   ddr3_loopback_traffic_checker #(
      .NUM_OF_TEST_DATA(300), .DATA_SEED(250), .TIMEOUT_CYCLES(1000)
   ) dut_b (
      .clk(clk), .reset(rst[1]), .start(start[1]),
      .write_enable(we[1]), .read_enable(re[1]), .i_user_data_address(addr[1]),
      .data_to_ram(dtr[1]), .wr_accept(wr_acc[1]), .rd_accept(rd_acc[1]),
      .rd_data_valid(rd_vld[1]), .data_from_ram(dfr[1]), .busy(busy[1]),
      .done(done[1]), .pass(pass[1]), .timeout(tmo[1]), .error_count(ec[1]),
      .first_error_address(fea[1]), .state(st[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Controller/memory model: accepts requests after a gap, returns read data after a latency.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         for (int m = 0; m < 2; m++) begin
            wr_acc[m] = 1'b0;
            rd_acc[m] = 1'b0;
            rd_vld[m] = 1'b0;
            dfr[m]    = 8'h00;
            if (rst[m]) begin
               wr_cnt[m] = 0;
               rd_cnt[m] = 0;
               exp_wa[m].delete();
               exp_wd[m].delete();
               exp_ra[m].delete();
               ret_due[m].delete();
               ret_dat[m].delete();
               continue;
            end
            if (we[m] || re[m]) chk("wr_rd_exclusive", 32'(we[m] & re[m]), 32'd0);
            if (we[m] && !no_wr[m]) begin
               wr_cnt[m]++;
               if (wr_cnt[m] >= wr_gap[m]) begin
                  wr_cnt[m] = 0;
                  wr_acc[m] = 1'b1;
                  mem[m][addr[m][8:0]] = dtr[m];
                  chk("wr_expected", 32'(exp_wa[m].size() > 0), 32'd1);
                  if (exp_wa[m].size() > 0) begin
                     chk("wr_addr", 32'(addr[m]), 32'(exp_wa[m].pop_front()));
                     chk("wr_data", 32'(dtr[m]), 32'(exp_wd[m].pop_front()));
                  end
               end
            end else begin
               wr_cnt[m] = 0;
            end
            if (re[m]) begin
               rd_cnt[m]++;
               if (rd_cnt[m] >= rd_gap[m]) begin
                  logic [7:0] d;
                  rd_cnt[m] = 0;
                  rd_acc[m] = 1'b1;
                  rd_total[m]++;
                  chk("rd_expected", 32'(exp_ra[m].size() > 0), 32'd1);
                  if (exp_ra[m].size() > 0) chk("rd_addr", 32'(addr[m]), 32'(exp_ra[m].pop_front()));
                  d = mem[m][addr[m][8:0]];
                  if (corrupt[m] == 1 && addr[m] == 18'd2) d = 8'h07;
                  if (corrupt[m] == 2) d = ~d;
                  ret_due[m].push_back(cyc + rd_lat[m]);
                  ret_dat[m].push_back(d);
               end
            end else begin
               rd_cnt[m] = 0;
            end
            if (ret_due[m].size() > 0 && ret_due[m][0] <= cyc) begin
               rd_vld[m] = 1'b1;
               dfr[m]    = ret_dat[m].pop_front();
               void'(ret_due[m].pop_front());
               if (rd_acc[m]) coinc[m]++;
            end
            if (spur[m]) begin
               wr_acc[m] = 1'b1;
               rd_acc[m] = 1'b1;
               rd_vld[m] = 1'b1;
               dfr[m]    = 8'hA5;
            end
         end
      end
   end

   task automatic check_zero(input int m, input string tag);
      chk({tag, "_we"},    32'(we[m]),   32'd0);
      chk({tag, "_re"},    32'(re[m]),   32'd0);
      chk({tag, "_addr"},  32'(addr[m]), 32'd0);
      chk({tag, "_data"},  32'(dtr[m]),  32'd0);
      chk({tag, "_busy"},  32'(busy[m]), 32'd0);
      chk({tag, "_done"},  32'(done[m]), 32'd0);
      chk({tag, "_pass"},  32'(pass[m]), 32'd0);
      chk({tag, "_tmo"},   32'(tmo[m]),  32'd0);
      chk({tag, "_ec"},    32'(ec[m]),   32'd0);
      chk({tag, "_fea"},   32'(fea[m]),  32'd0);
      chk({tag, "_state"}, 32'(st[m]),   32'd0);
   endtask

   task automatic start_run(input int m, input int n, input int seed, input string tag);
      for (int k = 0; k < n; k++) begin
         exp_wa[m].push_back(k);
         exp_wd[m].push_back((seed + k) % 256);
         exp_ra[m].push_back(k);
      end
      @(negedge clk);
      start[m] = 1'b1;
      @(negedge clk);
      start[m] = 1'b0;
      chk({tag, "_st_write"}, 32'(st[m]),   32'd1);
      chk({tag, "_st_we"},    32'(we[m]),   32'd1);
      chk({tag, "_st_addr"},  32'(addr[m]), 32'd0);
      chk({tag, "_st_data"},  32'(dtr[m]),  32'(seed % 256));
      chk({tag, "_st_busy"},  32'(busy[m]), 32'd1);
      chk({tag, "_st_done"},  32'(done[m]), 32'd0);
   endtask

   task automatic wait_done(input int m, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done[m]) break;
         @(negedge clk);
      end
   endtask

   task automatic check_result(input int m, input string tag, input int exp_pass,
                               input int exp_ec, input int exp_fea);
      chk({tag, "_done"},  32'(done[m]), 32'd1);
      chk({tag, "_pass"},  32'(pass[m]), 32'(exp_pass));
      chk({tag, "_ec"},    32'(ec[m]),   32'(exp_ec));
      chk({tag, "_fea"},   32'(fea[m]),  32'(exp_fea));
      chk({tag, "_tmo"},   32'(tmo[m]),  32'd0);
      chk({tag, "_busy"},  32'(busy[m]), 32'd0);
      chk({tag, "_state"}, 32'(st[m]),   32'd3);
      chk({tag, "_re"},    32'(re[m]),   32'd0);
      chk({tag, "_wq"},    32'(exp_wa[m].size()), 32'd0);
      chk({tag, "_rq"},    32'(exp_ra[m].size()), 32'd0);
   endtask

   initial begin
      int base;
      rst = 2'b11; start = 2'b00; no_wr = 2'b00; spur = 2'b00;
      wr_acc = '0; rd_acc = '0; rd_vld = '0; dfr = '0;
      wr_gap[0] = 5; rd_gap[0] = 5; rd_lat[0] = 10; corrupt[0] = 0;
      wr_gap[1] = 1; rd_gap[1] = 1; rd_lat[1] = 2;  corrupt[1] = 0;
      for (int m = 0; m < 2; m++) begin
         wr_cnt[m] = 0; rd_cnt[m] = 0; rd_total[m] = 0; coinc[m] = 0;
      end
      repeat (3) @(negedge clk);
      check_zero(0, "reset_a");
      check_zero(1, "reset_b");
      rst = 2'b00;
      repeat (2) @(negedge clk);

      // Clean loopback run
      start_run(0, 4, 0, "t1");
      wait_done(0, 400);
      check_result(0, "t1", 1, 0, 0);

      // Single corrupted word at address 2
      corrupt[0] = 1;
      start_run(0, 4, 0, "t2");
      wait_done(0, 400);
      check_result(0, "t2", 0, 1, 2);
      corrupt[0] = 0;

      // Write never accepted: watchdog expires 101 cycles after entering WRITE
      no_wr[0] = 1'b1;
      start_run(0, 4, 0, "t3");
      for (int i = 1; i <= 101; i++) begin
         @(negedge clk);
         if (i == 100) begin
            chk("t3_we_before", 32'(we[0]), 32'd1);
            chk("t3_st_before", 32'(st[0]), 32'd1);
         end
      end
      chk("t3_we",    32'(we[0]),   32'd0);
      chk("t3_re",    32'(re[0]),   32'd0);
      chk("t3_tmo",   32'(tmo[0]),  32'd1);
      chk("t3_done",  32'(done[0]), 32'd1);
      chk("t3_pass",  32'(pass[0]), 32'd0);
      chk("t3_busy",  32'(busy[0]), 32'd0);
      chk("t3_state", 32'(st[0]),   32'd4);
      exp_wa[0].delete(); exp_wd[0].delete(); exp_ra[0].delete();
      no_wr[0] = 1'b0;

      // Reset in the middle of READ
      start_run(0, 4, 0, "t4");
      base = rd_total[0];
      for (int i = 0; i < 400; i++) begin
         if (rd_total[0] >= base + 2) break;
         @(negedge clk);
      end
      chk("t4_in_read", 32'(st[0]), 32'd2);
      rst[0] = 1'b1;
      @(negedge clk);
      check_zero(0, "t4_abort");
      @(negedge clk);
      rst[0] = 1'b0;
      repeat (2) @(negedge clk);
      start_run(0, 4, 0, "t4r");
      wait_done(0, 400);
      check_result(0, "t4r", 1, 0, 0);

      // Spurious handshakes while idle/done; coincident accept+valid during the run
      rst[0] = 1'b1;
      repeat (2) @(negedge clk);
      rst[0] = 1'b0;
      @(negedge clk);
      spur[0] = 1'b1;
      repeat (3) @(negedge clk);
      spur[0] = 1'b0;
      @(negedge clk);
      check_zero(0, "t5_idle");
      base = coinc[0];
      start_run(0, 4, 0, "t5");
      wait_done(0, 400);
      check_result(0, "t5", 1, 0, 0);
      chk("t5_coincident_seen", 32'(coinc[0] > base), 32'd1);
      spur[0] = 1'b1;
      repeat (2) @(negedge clk);
      spur[0] = 1'b0;
      @(negedge clk);
      check_result(0, "t5_done_hold", 1, 0, 0);

      // 300 words from seed 250: data wraps 255 -> 0 at index 6
      start_run(1, 300, 250, "t6");
      wait_done(1, 3000);
      check_result(1, "t6", 1, 0, 0);
      corrupt[1] = 2;
      start_run(1, 300, 250, "t6bad");
      wait_done(1, 3000);
      check_result(1, "t6bad", 0, 255, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_time_limit observed=expired expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
